// File: rtl/uart_rx_ctrl.sv
// 16x-oversampled UART receiver (8 data bits, 1 stop) with a small receive FIFO.
// Define UART_RX_PARITY_EN to add an even-parity bit between the data and stop bits.
module uart_rx_ctrl #(
    parameter int OVS_DIV    = 27,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          en,
    input  logic                          din,
    output logic [7:0]                    m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic                          busy,
    output logic                          frame_err,
    output logic                          par_err,
    output logic                          overrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = $clog2(OVS_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(OVS_DIV - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_HIGH
    } state_t;

    state_t          state;
    logic            din_p0;
    logic            din_p1;
    logic [DW-1:0]   div_cnt;
    logic            tick;
    logic [3:0]      tick_cnt;
    logic [2:0]      bit_cnt;
    logic [7:0]      shift_reg;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            rx;
    logic            pop;
    logic            full;
    logic            can_push;
    logic            stop_tick;
    logic            push;

    // Input synchronizer: the line idles high, so the flops reset to 1.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            din_p0 <= 1'b1;
            din_p1 <= 1'b1;
        end else begin
            din_p0 <= din;
            din_p1 <= din_p0;
        end
    end

    assign rx = din_p1;

    // Oversample divider, held at zero while the receiver is disabled.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_cnt <= '0;
        end else if (!en || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign tick = en && (div_cnt == DIV_LAST);

    assign pop       = m_valid && m_ready;
    assign full      = (fifo_count == FULL_CNT);
    assign can_push  = !full || pop;
    assign stop_tick = tick && (state == STOP) && (tick_cnt == 4'd15);
    assign push      = stop_tick && rx && can_push;

    // Receive FSM
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            tick_cnt  <= 4'd0;
            bit_cnt   <= 3'd0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err   <= 1'b0;
`endif
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err   <= 1'b0;
`endif
            if (!en) begin
                state    <= IDLE;
                tick_cnt <= 4'd0;
                bit_cnt  <= 3'd0;
            end else if (tick) begin
                case (state)
                    IDLE: begin
                        if (!rx) begin
                            state    <= START;
                            tick_cnt <= 4'd0;
                        end
                    end
                    START: begin
                        tick_cnt <= tick_cnt + 4'd1;
                        if (tick_cnt == 4'd7) begin
                            if (rx) begin
                                state <= IDLE;
                            end else begin
                                state    <= DATA;
                                tick_cnt <= 4'd0;
                                bit_cnt  <= 3'd0;
                            end
                        end
                    end
                    DATA: begin
                        tick_cnt <= tick_cnt + 4'd1;
                        if (tick_cnt == 4'd15) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                                state <= PARITY;
`else
                                state <= STOP;
`endif
                            end
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    PARITY: begin
                        tick_cnt <= tick_cnt + 4'd1;
                        if (tick_cnt == 4'd15) begin
                            if (rx != ^shift_reg) begin
                                par_err <= 1'b1;
                                state   <= IDLE;
                            end else begin
                                state <= STOP;
                            end
                        end
                    end
`endif
                    STOP: begin
                        tick_cnt <= tick_cnt + 4'd1;
                        if (tick_cnt == 4'd15) begin
                            if (rx) begin
                                overrun <= !can_push;
                                state   <= IDLE;
                            end else begin
                                frame_err <= 1'b1;
                                state     <= WAIT_HIGH;
                            end
                        end
                    end
                    WAIT_HIGH: begin
                        if (rx) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifndef UART_RX_PARITY_EN
    assign par_err = 1'b0;
`endif

    // Data bits arrive LSB first, so each new bit enters at the top.
    always_ff @(posedge clk) begin
        if (tick && (state == DATA) && (tick_cnt == 4'd15)) begin
            shift_reg <= {rx, shift_reg[7:1]};
        end
    end

    assign busy = (state != IDLE);

    // Receive FIFO
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= shift_reg;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    assign m_valid = (fifo_count != '0);
    assign m_data  = m_valid ? mem[rd_ptr] : 8'h00;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed testbench for uart_rx_ctrl (OVS_DIV=2, FIFO_DEPTH=4): one bit = 32 clk.
// Build with UART_RX_PARITY_EN defined to include the parity scenario.
module tb_uart_rx_ctrl;

    localparam int OVS_DIV    = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int BIT_CLK    = 16 * OVS_DIV;

    logic       clk;
    logic       rstn;
    logic       en;
    logic       din;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       busy;
    logic       frame_err;
    logic       par_err;
    logic       overrun;
    logic [2:0] fifo_count;

    int checks = 0;
    int errors = 0;
    int ecnt;
    int n_ferr = 0;
    int n_perr = 0;
    int n_ovr  = 0;
`ifdef UART_RX_PARITY_EN
    logic par_flip;
`endif

    uart_rx_ctrl #(.OVS_DIV(OVS_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rstn(rstn), .en(en), .din(din),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .busy(busy), .frame_err(frame_err), .par_err(par_err),
        .overrun(overrun), .fifo_count(fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count of enabled clock edges: ticks fall on even counts.
    always @(posedge clk or negedge rstn) begin
        if (!rstn)   ecnt <= 0;
        else if (en) ecnt <= ecnt + 1;
        else         ecnt <= 0;
    end

    always @(negedge clk) begin
        if (frame_err) n_ferr++;
        if (par_err)   n_perr++;
        if (overrun)   n_ovr++;
    end

    task automatic idle(input int n);
        din = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Drives one frame from a negedge. With pop_at_push, m_ready is high only
    // for the edge where the stop bit is sampled (edge 3 + 16 + 32*9 [+32]).
    task automatic send_frame(input logic [7:0] data, input logic stop,
                              input logic pop_at_push, input int abort_t);
        logic [10:0] fv;
        int nb;
        int push_t;
        fv      = '1;
        fv[0]   = 1'b0;
        fv[8:1] = data;
`ifdef UART_RX_PARITY_EN
        fv[9]  = (^data) ^ par_flip;
        fv[10] = stop;
        nb     = 11;
        push_t = 338;
`else
        fv[9]  = stop;
        nb     = 10;
        push_t = 306;
`endif
        while (ecnt[0] == 1'b0) @(negedge clk);
        for (int t = 0; t < nb * BIT_CLK; t++) begin
            if (t == abort_t) return;
            din = fv[t / BIT_CLK];
            if (pop_at_push) m_ready = (t == push_t);
            @(negedge clk);
        end
    endtask

    task automatic send_byte(input logic [7:0] data);
        send_frame(data, 1'b1, 1'b0, -1);
        idle(BIT_CLK);
    endtask

    task automatic pop_one();
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++;
        if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", m_valid); end
        checks++;
        if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
        checks++;
        if (m_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", m_data); end
        checks++;
        if ({frame_err, par_err, overrun} !== 3'b000)
            begin errors++; $display("FAIL reset_pulses: got %b want 000", {frame_err, par_err, overrun}); end
    endtask

    task automatic test_single_byte();
        int f0 = n_ferr, p0 = n_perr, o0 = n_ovr;
        send_byte(8'hA5);
        checks++;
        if (m_data !== 8'hA5) begin errors++; $display("FAIL single_data: got %h want a5", m_data); end
        checks++;
        if (m_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", m_valid); end
        checks++;
        if (fifo_count !== 3'd1) begin errors++; $display("FAIL single_count: got %0d want 1", fifo_count); end
        checks++;
        if ((n_ferr - f0) + (n_perr - p0) + (n_ovr - o0) != 0)
            begin errors++; $display("FAIL single_errs: got %0d pulses want 0", (n_ferr - f0) + (n_perr - p0) + (n_ovr - o0)); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL single_busy: got %b want 0", busy); end
        pop_one();
        checks++;
        if (m_valid !== 1'b0 || fifo_count !== 3'd0)
            begin errors++; $display("FAIL single_pop: got valid=%b count=%0d want 0/0", m_valid, fifo_count); end
    endtask

    task automatic test_glitch();
        int f0 = n_ferr, p0 = n_perr, o0 = n_ovr;
        din = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL glitch_start: got busy=%b want 1", busy); end
        repeat (2) @(negedge clk);
        idle(40);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy: got %b want 0", busy); end
        checks++;
        if (fifo_count !== 3'd0) begin errors++; $display("FAIL glitch_count: got %0d want 0", fifo_count); end
        checks++;
        if ((n_ferr - f0) + (n_perr - p0) + (n_ovr - o0) != 0)
            begin errors++; $display("FAIL glitch_errs: got %0d pulses want 0", (n_ferr - f0) + (n_perr - p0) + (n_ovr - o0)); end
    endtask

    task automatic test_frame_error();
        int f0 = n_ferr;
        send_frame(8'h3C, 1'b0, 1'b0, -1);
        repeat (100) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL ferr_wait_high: got busy=%b want 1", busy); end
        idle(64);
        send_byte(8'h11);
        checks++;
        if (n_ferr - f0 != 1) begin errors++; $display("FAIL ferr_pulses: got %0d want 1", n_ferr - f0); end
        checks++;
        if (fifo_count !== 3'd1) begin errors++; $display("FAIL ferr_count: got %0d want 1", fifo_count); end
        checks++;
        if (m_data !== 8'h11) begin errors++; $display("FAIL ferr_data: got %h want 11", m_data); end
        pop_one();
    endtask

    task automatic test_overrun();
        int o0 = n_ovr;
        logic [7:0] exp;
        for (int i = 1; i <= 5; i++) send_byte(8'(i));
        checks++;
        if (fifo_count !== 3'd4) begin errors++; $display("FAIL ovr_count: got %0d want 4", fifo_count); end
        checks++;
        if (n_ovr - o0 != 1) begin errors++; $display("FAIL ovr_pulses: got %0d want 1", n_ovr - o0); end
        for (int i = 1; i <= 4; i++) begin
            exp = 8'(i);
            checks++;
            if (m_data !== exp || m_valid !== 1'b1)
                begin errors++; $display("FAIL ovr_pop%0d: got %h valid=%b want %h", i, m_data, m_valid, exp); end
            pop_one();
        end
        checks++;
        if (fifo_count !== 3'd0) begin errors++; $display("FAIL ovr_drain: got %0d want 0", fifo_count); end
    endtask

    task automatic test_full_plus_pop();
        int o0 = n_ovr;
        logic [7:0] exp;
        for (int i = 0; i < 4; i++) send_byte(8'h10 + 8'(i));
        send_frame(8'h14, 1'b1, 1'b1, -1);
        idle(BIT_CLK);
        checks++;
        if (n_ovr - o0 != 0) begin errors++; $display("FAIL fpp_overrun: got %0d want 0", n_ovr - o0); end
        checks++;
        if (fifo_count !== 3'd4) begin errors++; $display("FAIL fpp_count: got %0d want 4", fifo_count); end
        for (int i = 1; i <= 4; i++) begin
            exp = 8'h10 + 8'(i);
            checks++;
            if (m_data !== exp) begin errors++; $display("FAIL fpp_pop%0d: got %h want %h", i, m_data, exp); end
            pop_one();
        end
    endtask

    task automatic test_en_drop();
        int f0 = n_ferr, p0 = n_perr, o0 = n_ovr;
        send_byte(8'hAA);
        send_frame(8'h55, 1'b1, 1'b0, 150);
        en = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL endrop_busy: got %b want 0", busy); end
        din = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if (fifo_count !== 3'd1 || m_data !== 8'hAA)
            begin errors++; $display("FAIL endrop_fifo: got count=%0d data=%h want 1/aa", fifo_count, m_data); end
        pop_one();
        checks++;
        if (fifo_count !== 3'd0) begin errors++; $display("FAIL endrop_pop: got %0d want 0", fifo_count); end
        en = 1'b1;
        idle(BIT_CLK);
        send_byte(8'h5A);
        checks++;
        if (m_data !== 8'h5A || fifo_count !== 3'd1)
            begin errors++; $display("FAIL endrop_resume: got %h count=%0d want 5a/1", m_data, fifo_count); end
        checks++;
        if ((n_ferr - f0) + (n_perr - p0) + (n_ovr - o0) != 0)
            begin errors++; $display("FAIL endrop_errs: got %0d pulses want 0", (n_ferr - f0) + (n_perr - p0) + (n_ovr - o0)); end
        pop_one();
    endtask

    task automatic test_reset_midframe();
        send_byte(8'hC3);
        send_frame(8'h3E, 1'b1, 1'b0, 200);
        rstn = 1'b0;
        #1;
        checks++;
        if (fifo_count !== 3'd0 || m_valid !== 1'b0 || busy !== 1'b0)
            begin errors++; $display("FAIL rstmid_clear: got count=%0d valid=%b busy=%b want 0/0/0", fifo_count, m_valid, busy); end
        @(negedge clk);
        rstn = 1'b1;
        idle(40);
        send_byte(8'h81);
        checks++;
        if (m_data !== 8'h81 || fifo_count !== 3'd1)
            begin errors++; $display("FAIL rstmid_resume: got %h count=%0d want 81/1", m_data, fifo_count); end
        pop_one();
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        int p0 = n_perr;
        par_flip = 1'b1;
        send_frame(8'h07, 1'b1, 1'b0, -1);
        idle(BIT_CLK);
        par_flip = 1'b0;
        checks++;
        if (n_perr - p0 != 1) begin errors++; $display("FAIL par_pulse: got %0d want 1", n_perr - p0); end
        checks++;
        if (fifo_count !== 3'd0) begin errors++; $display("FAIL par_drop: got %0d want 0", fifo_count); end
        send_byte(8'h07);
        checks++;
        if (m_data !== 8'h07 || fifo_count !== 3'd1)
            begin errors++; $display("FAIL par_good: got %h count=%0d want 07/1", m_data, fifo_count); end
        checks++;
        if (n_perr - p0 != 1) begin errors++; $display("FAIL par_extra: got %0d want 1", n_perr - p0); end
        pop_one();
    endtask
`endif

    initial begin
        rstn    = 1'b0;
        en      = 1'b1;
        din     = 1'b1;
        m_ready = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_flip = 1'b0;
`endif
        repeat (3) @(negedge clk);
        test_reset();
        rstn = 1'b1;
        idle(40);
        test_single_byte();
        test_glitch();
        test_frame_error();
        test_overrun();
        test_full_plus_pop();
        test_en_drop();
        test_reset_midframe();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter OVS_DIV, default 27: clk cycles per 16x-oversample tick, legal range 2..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: receive FIFO entries, power of two, 2..16.
REQ-003 SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-004 SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port en, input, 1 bit: receiver enable.
REQ-006 SHALL have port din, input, 1 bit: asynchronous serial line, idle high.
REQ-007 SHALL have port m_data, output, 8 bits: FIFO head byte.
REQ-008 SHALL have port m_valid, output, 1 bit: FIFO non-empty.
REQ-009 SHALL have port m_ready, input, 1 bit: consumer accepts the head byte when m_valid and m_ready are both high.
REQ-010 SHALL have port busy, output, 1 bit: high whenever the FSM is not IDLE.
REQ-011 SHALL have port frame_err, output, 1 bit: one-cycle pulse when the stop bit samples 0.
REQ-012 SHALL have port par_err, output, 1 bit: one-cycle pulse on parity mismatch.
REQ-013 SHALL have port overrun, output, 1 bit: one-cycle pulse when a good byte is dropped because the FIFO is full.
REQ-014 SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1 bits: current FIFO occupancy.

Function
REQ-015 SHALL pass din through a 2-flop synchronizer; all sampling uses the synchronized value.
REQ-016 SHALL emit a tick every OVS_DIV clk cycles from a free-running divider; the divider runs only while en=1.
REQ-017 SHALL use FSM states IDLE, START, DATA, PARITY (PARITY_EN only), STOP and WAIT_HIGH.
REQ-018 SHALL, in IDLE on a tick with din=0, go to START and clear the 4-bit tick counter.
REQ-019 SHALL, in START, sample din on the 8th tick (mid-bit): 1 means a glitch, go to IDLE with no error; 0 means go to DATA.
REQ-020 SHALL, in DATA, sample din every 16th tick, shift bits in LSB first, and after 8 bits go to PARITY if enabled, else STOP.
REQ-021 SHALL, in STOP, sample din on the 16th tick:
  - 1, FIFO not full: push the byte, go to IDLE.
  - 1, FIFO full and no pop in the same cycle: drop the byte, pulse overrun, go to IDLE.
  - 0: drop the byte, pulse frame_err, go to WAIT_HIGH.
REQ-022 SHALL leave WAIT_HIGH for IDLE only on a tick with din=1.
REQ-023 SHALL accept the push when the FIFO is full and a pop occurs in the same cycle; no overrun in that case.
REQ-024 SHALL assert m_valid the cycle after a push into an empty FIFO; m_data SHALL be held stable while m_valid=1 and m_ready=0.
REQ-025 SHALL apply a simultaneous push and pop on a non-empty FIFO with fifo_count unchanged.
REQ-026 SHALL wrap FIFO read and write pointers modulo FIFO_DEPTH.
REQ-027 SHALL, when en drops mid-frame, go to IDLE on the next clk with no push or error pulse; FIFO contents and the pop path remain operational.

Reset
REQ-028 SHALL, while rstn=0, asynchronously force:
  - state IDLE; divider, tick counter and FIFO pointers to 0;
  - synchronizer flops to 1;
  - m_valid, busy, frame_err, par_err, overrun to 0;
  - fifo_count 0, m_data 8'h00.
REQ-029 SHALL discard the partial frame and FIFO contents when reset occurs mid-frame; reception resumes from IDLE after rstn rises.

Configuration
REQ-030 SHALL compile the parity stage only when UART_RX_PARITY_EN is defined. When defined, PARITY samples an even-parity bit on the 16th tick; a mismatch drops the byte, pulses par_err and goes to IDLE; a match goes to STOP. When undefined, the PARITY state is absent, par_err is tied to 0, and DATA goes directly to STOP.

Verification
REQ-031 SHALL test a single byte: OVS_DIV=2, en=1, din frame 8'hA5 with stop=1 -> m_data=8'hA5, m_valid=1, fifo_count=1, no error pulses.
REQ-032 SHALL test a start glitch: din low for 8 clk then high -> FSM returns to IDLE, busy low, no push, no errors.
REQ-033 SHALL test a framing error: frame 8'h3C with stop=0, line held low 100 clk, then frame 8'h11 -> one frame_err pulse, 8'h11 is the only byte received.
REQ-034 SHALL test overrun: m_ready=0, FIFO_DEPTH=4, send 8'h01..8'h05 -> fifo_count=4, one overrun pulse; pop yields 01,02,03,04.
REQ-035 SHALL test full-plus-pop: FIFO full, m_ready=1 in the cycle of the stop-bit push -> no overrun, fifo_count stays 4.
REQ-036 SHALL test parity (UART_RX_PARITY_EN): 8'h07 with parity=0 -> par_err pulse, no push; 8'h07 with parity=1 -> byte pushed.
